dp_executor: RTL and testbench

Shared datapath that executes the 32-bit instructions issued by the ant draw/update controllers. It decodes LOAD, STORE, DRAW and NOP, and drives a 1-cycle-latency synchronous RAM and the VGA adapter's pixel-plot port. It returns finished_dp/result_dp to the controller. One instruction is in flight at a time; arbitration between controllers happens upstream.

---
 rtl/dp_executor_if.sv | 34 +++
 rtl/dp_executor.sv | 170 +++++++++++++++++
 tb/tb_dp_executor.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dp_executor_if.sv
// rtl/dp_executor_if.sv - command, RAM and pixel-plot signals of the shared datapath
interface dp_executor_if #(
  parameter int INSTR_W  = 32,
  parameter int ADDR_W   = 16,
  parameter int RESULT_W = 16,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic                start_dp;
  logic [INSTR_W-1:0]  instruction_dp;
  logic                finished_dp;
  logic [RESULT_W-1:0] result_dp;
  logic [ADDR_W-1:0]   mem_address;
  logic [RESULT_W-1:0] mem_wdata;
  logic                mem_we;
  logic [RESULT_W-1:0] mem_rdata;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  modport master (
    output start_dp, instruction_dp, mem_rdata,
    input  finished_dp, result_dp, mem_address, mem_wdata, mem_we,
    input  vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start_dp, instruction_dp, mem_rdata,
    output finished_dp, result_dp, mem_address, mem_wdata, mem_we,
    output vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/dp_executor.sv
// rtl/dp_executor.sv - executes one LOAD/STORE/DRAW/NOP instruction at a time
module dp_executor #(
  parameter int INSTR_W  = 32,
  parameter int ADDR_W   = 16,
  parameter int RESULT_W = 16,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int BLOCK_W  = 4,
  parameter int BLOCK_H  = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic         clock,
  input logic         resetn,
  dp_executor_if.slave bus
);
  localparam int BX_W = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam int BY_W = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;

  typedef enum logic [2:0] {IDLE, L_ADDR, L_WAIT, L_CAP, S_WRITE, D_PIXEL, DONE} state_t;

  state_t state, state_d;
  logic                start_prev;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [BX_W-1:0]     bx, bx_d;
  logic [BY_W-1:0]     by, by_d;
  logic                finished_q, finished_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [RESULT_W-1:0] wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d;

  logic           accept;
  logic [3:0]     opcode_in;
  logic           last_px;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;

  assign accept    = (state == IDLE) && bus.start_dp && !start_prev;
  assign opcode_in = bus.instruction_dp[31:28];
  assign last_px   = (bx == BX_W'(BLOCK_W - 1)) && (by == BY_W'(BLOCK_H - 1));
  // One bit wider than the screen coordinate so blocks at the right/bottom edge never wrap on-screen.
  assign sum_x     = {1'b0, instr_q[7:0]} + (X_W + 1)'(bx);
  assign sum_y     = {1'b0, instr_q[14:8]} + (Y_W + 1)'(by);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      start_prev <= 1'b0;
      instr_q    <= '0;
      bx         <= '0;
      by         <= '0;
      finished_q <= 1'b1;
      result_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
    end else begin
      state      <= state_d;
      start_prev <= bus.start_dp;
      instr_q    <= instr_d;
      bx         <= bx_d;
      by         <= by_d;
      finished_q <= finished_d;
      result_q   <= result_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (opcode_in)
            4'd1:    state_d = D_PIXEL;
            4'd2:    state_d = L_ADDR;
            4'd3:    state_d = S_WRITE;
            default: state_d = DONE;
          endcase
        end
      end
      L_ADDR:  state_d = L_WAIT;
      L_WAIT:  state_d = L_CAP;
      L_CAP:   state_d = IDLE;
      S_WRITE: state_d = DONE;
      D_PIXEL: state_d = last_px ? DONE : D_PIXEL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_d    = instr_q;
    bx_d       = bx;
    by_d       = by;
    finished_d = finished_q;
    result_d   = result_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    plot_d     = plot_q;
    case (state)
      IDLE: begin
        if (accept) begin
          instr_d    = bus.instruction_dp;
          finished_d = 1'b0;
          bx_d       = '0;
          by_d       = '0;
        end
      end
      L_ADDR: addr_d = instr_q[ADDR_W-1:0];
      L_CAP: begin
        result_d   = bus.mem_rdata;
        finished_d = 1'b1;
      end
      S_WRITE: begin
        addr_d  = instr_q[ADDR_W-1:0];
        wdata_d = {{(RESULT_W - 12){1'b0}}, instr_q[27:16]};
        we_d    = 1'b1;
      end
      D_PIXEL: begin
        x_d      = sum_x[X_W-1:0];
        y_d      = sum_y[Y_W-1:0];
        colour_d = instr_q[18] ? instr_q[17:15] : '0;
        plot_d   = (sum_x < (X_W + 1)'(SCREEN_W)) && (sum_y < (Y_W + 1)'(SCREEN_H));
        if (bx == BX_W'(BLOCK_W - 1)) begin
          bx_d = '0;
          by_d = by + 1'b1;
        end else begin
          bx_d = bx + 1'b1;
        end
      end
      DONE: begin
        we_d       = 1'b0;
        plot_d     = 1'b0;
        finished_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.finished_dp = finished_q;
  assign bus.result_dp   = result_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_we      = we_q;
  assign bus.vga_x       = x_q;
  assign bus.vga_y       = y_q;
  assign bus.vga_colour  = colour_q;
  assign bus.vga_plot    = plot_q;
endmodule

// File: tb/tb_dp_executor.sv
// tb/tb_dp_executor.sv - directed self-checking bench for dp_executor
module tb_dp_executor;
  logic clock = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  int   we_cnt = 0;
  int   plot_cnt = 0;
  int   overlap = 0;
  logic [15:0] ram [0:65535];

  dp_executor_if bus ();

  dp_executor dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.mem_we) ram[bus.mem_address] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_address];
  end

  always @(negedge clock) begin
    if (bus.mem_we) we_cnt++;
    if (bus.vga_plot) plot_cnt++;
    if ((bus.mem_we && bus.vga_plot) || (bus.finished_dp && (bus.mem_we || bus.vga_plot))) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mk_draw(input logic p, input logic [2:0] c,
                                          input logic [6:0] y, input logic [7:0] x);
    return {4'd1, 9'd0, p, c, y, x};
  endfunction

  task automatic issue(input logic [31:0] instr, input string tag);
    bus.instruction_dp = instr;
    bus.start_dp = 1'b1;
    step();
    check(tag, {31'd0, bus.finished_dp}, 32'd0);
    bus.start_dp = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] instr);
    issue(instr, "store_e0");
    step();
    check("store_e1", {bus.mem_we, bus.mem_address, bus.mem_wdata}, {1'b1, instr[15:0], 4'd0, instr[27:16]});
    step();
    check("store_e2", {bus.finished_dp, bus.mem_we}, 32'b10);
  endtask

  task automatic do_load(input logic [31:0] instr, input logic [15:0] exp, input string tag);
    issue(instr, "load_e0");
    step();
    check("load_e1", {bus.finished_dp, bus.mem_we, bus.mem_address}, {2'b00, instr[15:0]});
    step();
    check("load_e2", {31'd0, bus.finished_dp}, 32'd0);
    step();
    check(tag, {bus.finished_dp, bus.result_dp}, {1'b1, exp});
  endtask

  initial begin
    logic [7:0] ex;
    logic [6:0] ey;
    int base;
    int idle_busy;
    resetn = 1'b0;
    bus.start_dp = 1'b0;
    bus.instruction_dp = '0;
    repeat (3) step();
    check("reset_finished", {31'd0, bus.finished_dp}, 32'd1);
    check("reset_result", {16'd0, bus.result_dp}, 32'd0);
    check("reset_mem", {bus.mem_we, bus.mem_address, bus.mem_wdata}, 32'd0);
    check("reset_vga", {bus.vga_plot, bus.vga_colour, bus.vga_y, bus.vga_x}, 32'd0);
    resetn = 1'b1;
    step();

    // NOP held for two cycles
    bus.instruction_dp = 32'h0000_0000;
    bus.start_dp = 1'b1;
    step();
    check("nop_e0", {31'd0, bus.finished_dp}, 32'd0);
    step();
    check("nop_e1", {31'd0, bus.finished_dp}, 32'd1);
    bus.start_dp = 1'b0;
    step();
    check("nop_idle", {bus.finished_dp, bus.result_dp}, {1'b1, 16'd0});
    check("nop_strobes", we_cnt + plot_cnt, 32'd0);

    do_store(32'h30AB_0005);
    check("store_one_write", we_cnt, 32'd1);
    do_load(32'h2000_0005, 16'h00AB, "load_result");
    check("load_no_write", we_cnt, 32'd1);

    // Block fully on screen
    base = plot_cnt;
    issue(mk_draw(1'b1, 3'd4, 7'd60, 8'd10), "draw_e0");
    for (int i = 0; i < 16; i++) begin
      step();
      ex = 8'(10 + i % 4);
      ey = 7'(60 + i / 4);
      check("draw_px", {bus.finished_dp, bus.vga_plot, bus.vga_colour, bus.vga_y, bus.vga_x},
            {12'd0, 1'b0, 1'b1, 3'd4, ey, ex});
    end
    step();
    check("draw_end", {bus.finished_dp, bus.vga_plot}, 32'b10);
    check("draw_count", plot_cnt - base, 32'd16);

    // Block clipped at bottom-right corner
    base = plot_cnt;
    issue(mk_draw(1'b1, 3'd7, 7'd118, 8'd158), "edge_e0");
    for (int i = 0; i < 16; i++) begin
      step();
      ex = 8'(158 + i % 4);
      ey = 7'(118 + i / 4);
      check("edge_px", {bus.finished_dp, bus.vga_plot, bus.vga_y, bus.vga_x},
            {15'd0, 1'b0, ((i % 4) < 2) && ((i / 4) < 2), ey, ex});
    end
    step();
    check("edge_end", {bus.finished_dp, bus.vga_plot}, 32'b10);
    check("edge_count", plot_cnt - base, 32'd4);

    // start_dp held high for 30 cycles
    do_store(32'h3123_0010);
    bus.instruction_dp = 32'h2000_0010;
    bus.start_dp = 1'b1;
    step();
    check("held_e0", {31'd0, bus.finished_dp}, 32'd0);
    step();
    step();
    step();
    check("held_e3", {bus.finished_dp, bus.result_dp}, {1'b1, 16'h0123});
    idle_busy = 0;
    repeat (26) begin
      step();
      if (!bus.finished_dp) idle_busy++;
    end
    check("held_no_retrigger", idle_busy, 32'd0);
    bus.start_dp = 1'b0;
    step();
    do_load(32'h2000_0005, 16'h00AB, "second_load");

    // Reset in the middle of a draw
    issue(mk_draw(1'b1, 3'd2, 7'd10, 8'd20), "abort_e0");
    repeat (5) step();
    check("abort_px5", {bus.vga_plot, bus.vga_y, bus.vga_x}, {16'd0, 1'b1, 7'd11, 8'd20});
    resetn = 1'b0;
    step();
    check("abort_reset", {bus.finished_dp, bus.vga_plot, bus.mem_we}, 32'b100);
    resetn = 1'b1;
    step();
    check("abort_quiet", {bus.finished_dp, bus.vga_plot}, 32'b10);
    do_store(32'h3055_0020);
    do_load(32'h2000_0020, 16'h0055, "post_reset_load");

    check("no_overlap", overlap, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
